tlb_op_ctrl: RTL and testbench
==============================

TLB_OP_CTRL -- requirements
Module: tlb_op_ctrl

Interface
REQ-001 SHALL have ports: clk in 1, CPU clock; all state updates on its rising edge.
REQ-002 SHALL have port: rst in 1, synchronous, active-high reset.
REQ-003 SHALL have ports: op_valid_i in 1, TLB instruction request; op_i in 3, operation code (001 TLBR, 010 TLBWI, 011 TLBWR, 100 TLBP, others illegal).
REQ-004 SHALL have ports: index_i, random_i, entryhi_i, entrylo0_i, entrylo1_i in 32 each, live CP0 register values.
REQ-005 SHALL have ports: tlb_re_o out 1, tlb_we_o out 1, tlb_addr_o out 4, tlb_wdata_o out 96 ({entryhi, entrylo0, entrylo1}) and tlb_rdata_i in 96, TLB array port; read data valid exactly one cycle after tlb_re_o.
REQ-006 SHALL have ports: cp0_tlb_we_o out 1, cp0_entryhi_o, cp0_entrylo0_o, cp0_entrylo1_o out 32 each, CP0 TLBR writeback.
REQ-007 SHALL have ports: cp0_index_we_o out 1, cp0_index_o out 32, CP0 Index writeback for TLBP.
REQ-008 SHALL have ports: busy_o out 1, pipeline stall request; done_o out 1, one-cycle completion pulse.

Function
REQ-009 SHALL implement FSM states IDLE, RD_REQ, RD_RSP, WRITE, PROBE; busy_o = (state != IDLE).
REQ-010 SHALL accept a request only in IDLE with op_valid_i=1 and legal op_i; acceptance cycle T samples idx=index_i[3:0], rnd=random_i[3:0], hi=entryhi_i, lo0=entrylo0_i, lo1=entrylo1_i into registers.
REQ-011 SHALL ignore illegal op_i and any op_valid_i while busy (no state change, no strobes).
REQ-012 TLBR: T+1 RD_REQ with tlb_re_o=1, tlb_addr_o=idx; T+2 RD_RSP with cp0_tlb_we_o=1, done_o=1, cp0_entry*_o = fields of tlb_rdata_i; T+3 IDLE.
REQ-013 TLBWI/TLBWR: T+1 WRITE with tlb_we_o=1, done_o=1, tlb_addr_o = idx (TLBWI) or rnd (TLBWR), tlb_wdata_o = {hi with bits 12:8 forced 0, lo0, lo1}; T+2 IDLE.
REQ-014 TLBP: PROBE issues tlb_re_o=1 with 4-bit counter cnt=0,1,..,15 on cycles T+1..T+16; entry cnt compared one cycle after its read.
REQ-015 TLBP match: rdata[95:77]==hi[31:13] AND (rdata[64]&rdata[32] (G) OR rdata[71:64]==hi[7:0]).
REQ-016 TLBP on first match of entry k (cycle T+2+k): cp0_index_we_o=1, cp0_index_o={28'b0,k}, done_o=1, then IDLE; lowest matching index wins; any read issued in that cycle is discarded.
REQ-017 TLBP no match after entry 15 compared (cycle T+17): cp0_index_we_o=1, cp0_index_o=32'h8000_0000, done_o=1, then IDLE.
REQ-018 cnt SHALL not wrap: no read issued after cnt=15; tlb_re_o=0 on compare-only cycle T+17.
REQ-019 All strobes (tlb_re_o, tlb_we_o, cp0_tlb_we_o, cp0_index_we_o, done_o) SHALL be 0 except in the cycles listed above; each is asserted at most one cycle per operation except tlb_re_o in PROBE.
REQ-020 Changes on CP0 inputs after acceptance SHALL NOT affect the running operation.
REQ-021 A new request SHALL be accepted no earlier than the cycle in which state has returned to IDLE (after done_o).

Reset
REQ-022 rst=1 at a clock edge SHALL force IDLE, cnt=0, all captured registers 0, all outputs 0 (busy_o=0), regardless of state.
REQ-023 Reset mid-operation SHALL abort without any further tlb_we_o, cp0_tlb_we_o or cp0_index_we_o pulse.

Verification
REQ-024 TLBWI, index_i=5, entryhi_i=32'hABCD_F1FF -> T+1 tlb_we_o=1, tlb_addr_o=5, tlb_wdata_o[95:64]=32'hABCD_E0FF, done_o=1; T+2 busy_o=0.
REQ-025 TLBR, index_i=3, entry 3 preloaded {32'h1000_2005, 32'h11, 32'h22} -> T+2 cp0_tlb_we_o=1 with those three values, done_o=1.
REQ-026 TLBP, hi=32'h0040_0007, entries 6 and 9 match -> done_o at T+8, cp0_index_o=32'h0000_0006.
REQ-027 TLBP, no entry matches (ASID differs, G=0) -> done_o at T+17, cp0_index_o=32'h8000_0000, exactly 16 read pulses.
REQ-028 TLBWR, random_i=12, op_valid_i reasserted with TLBWI on T+1 -> single write to address 12, second request ignored.
REQ-029 TLBP started, rst=1 at T+5 -> T+6 busy_o=0, no cp0_index_we_o pulse ever.

Source files
------------

// File: rtl/tlb_op_ctrl.sv
// TLB instruction sequencer: turns TLBR/TLBWI/TLBWR/TLBP requests into TLB array
// accesses and CP0 register writebacks, stalling the pipeline while it works.
module tlb_op_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        op_valid_i,
   input  logic [2:0]  op_i,
   input  logic [31:0] index_i,
   input  logic [31:0] random_i,
   input  logic [31:0] entryhi_i,
   input  logic [31:0] entrylo0_i,
   input  logic [31:0] entrylo1_i,
   output logic        tlb_re_o,
   output logic        tlb_we_o,
   output logic [3:0]  tlb_addr_o,
   output logic [95:0] tlb_wdata_o,
   input  logic [95:0] tlb_rdata_i,
   output logic        cp0_tlb_we_o,
   output logic [31:0] cp0_entryhi_o,
   output logic [31:0] cp0_entrylo0_o,
   output logic [31:0] cp0_entrylo1_o,
   output logic        cp0_index_we_o,
   output logic [31:0] cp0_index_o,
   output logic        busy_o,
   output logic        done_o
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] RD_REQ = 3'd1;
   localparam logic [2:0] RD_RSP = 3'd2;
   localparam logic [2:0] WRITE  = 3'd3;
   localparam logic [2:0] PROBE  = 3'd4;

   localparam logic [2:0] OP_TLBR  = 3'b001;
   localparam logic [2:0] OP_TLBWI = 3'b010;
   localparam logic [2:0] OP_TLBWR = 3'b011;
   localparam logic [2:0] OP_TLBP  = 3'b100;

   localparam logic [31:0] HI_WR_MASK = 32'hFFFF_E0FF;
   localparam logic [31:0] PROBE_MISS = 32'h8000_0000;

   logic [2:0]  state;
   logic [2:0]  next_state;
   logic [2:0]  op;
   logic [3:0]  idx;
   logic [3:0]  rnd;
   logic [31:0] hi;
   logic [31:0] lo0;
   logic [31:0] lo1;
   logic [3:0]  cnt;
   logic        cmp_v;
   logic [3:0]  cmp_idx;
   logic        last_rd;
   logic        accept;
   logic        probe_hit;
   logic        probe_miss;

   function automatic logic legal_op(input logic [2:0] code);
      case (code)
         OP_TLBR, OP_TLBWI, OP_TLBWR, OP_TLBP: legal_op = 1'b1;
         default:                              legal_op = 1'b0;
      endcase
   endfunction

   // Global bit is taken from entryhi bit 0 and entrylo0 bit 0 of the stored entry.
   function automatic logic entry_match(input logic [95:0] entry, input logic [31:0] key);
      logic vpn_eq;
      logic asid_eq;
      logic glob;
      vpn_eq      = (entry[95:77] == key[31:13]);
      asid_eq     = (entry[71:64] == key[7:0]);
      glob        = entry[64] & entry[32];
      entry_match = vpn_eq & (glob | asid_eq);
   endfunction

   // Probe outcome for the entry whose read data is on tlb_rdata_i this cycle.
   always_comb begin
      probe_hit  = 1'b0;
      probe_miss = 1'b0;
      if ((state == PROBE) && cmp_v) begin
         probe_hit  = entry_match(tlb_rdata_i, hi);
         probe_miss = ~probe_hit & (cmp_idx == 4'd15);
      end else begin
         probe_hit  = 1'b0;
         probe_miss = 1'b0;
      end
   end

   // Next-state logic and request acceptance.
   always_comb begin
      accept     = 1'b0;
      next_state = state;
      case (state)
         IDLE: begin
            if (op_valid_i && legal_op(op_i)) begin
               accept = 1'b1;
               case (op_i)
                  OP_TLBR: next_state = RD_REQ;
                  OP_TLBP: next_state = PROBE;
                  default: next_state = WRITE;
               endcase
            end else begin
               accept     = 1'b0;
               next_state = IDLE;
            end
         end
         RD_REQ:  next_state = RD_RSP;
         RD_RSP:  next_state = IDLE;
         WRITE:   next_state = IDLE;
         PROBE: begin
            if (probe_hit || probe_miss) begin
               next_state = IDLE;
            end else begin
               next_state = PROBE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // State, captured request operands and probe sweep bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         op      <= 3'd0;
         idx     <= 4'd0;
         rnd     <= 4'd0;
         hi      <= 32'd0;
         lo0     <= 32'd0;
         lo1     <= 32'd0;
         cnt     <= 4'd0;
         cmp_v   <= 1'b0;
         cmp_idx <= 4'd0;
         last_rd <= 1'b0;
      end else begin
         state <= next_state;
         if (accept) begin
            op      <= op_i;
            idx     <= index_i[3:0];
            rnd     <= random_i[3:0];
            hi      <= entryhi_i;
            lo0     <= entrylo0_i;
            lo1     <= entrylo1_i;
            cnt     <= 4'd0;
            cmp_v   <= 1'b0;
            cmp_idx <= 4'd0;
            last_rd <= 1'b0;
         end else if ((state == PROBE) && !last_rd) begin
            // The entry read this cycle is compared next cycle; stop issuing after entry 15.
            cmp_v   <= 1'b1;
            cmp_idx <= cnt;
            if (cnt == 4'd15) begin
               last_rd <= 1'b1;
            end else begin
               cnt <= cnt + 4'd1;
            end
         end
      end
   end

   // Output decode; everything is zero outside the cycles that own a strobe.
   always_comb begin
      tlb_re_o       = 1'b0;
      tlb_we_o       = 1'b0;
      tlb_addr_o     = 4'd0;
      tlb_wdata_o    = 96'd0;
      cp0_tlb_we_o   = 1'b0;
      cp0_entryhi_o  = 32'd0;
      cp0_entrylo0_o = 32'd0;
      cp0_entrylo1_o = 32'd0;
      cp0_index_we_o = 1'b0;
      cp0_index_o    = 32'd0;
      done_o         = 1'b0;
      busy_o         = (state != IDLE);
      case (state)
         RD_REQ: begin
            tlb_re_o   = 1'b1;
            tlb_addr_o = idx;
         end
         RD_RSP: begin
            cp0_tlb_we_o   = 1'b1;
            done_o         = 1'b1;
            cp0_entryhi_o  = tlb_rdata_i[95:64];
            cp0_entrylo0_o = tlb_rdata_i[63:32];
            cp0_entrylo1_o = tlb_rdata_i[31:0];
         end
         WRITE: begin
            tlb_we_o    = 1'b1;
            done_o      = 1'b1;
            tlb_addr_o  = (op == OP_TLBWR) ? rnd : idx;
            tlb_wdata_o = {hi & HI_WR_MASK, lo0, lo1};
         end
         PROBE: begin
            tlb_re_o   = ~last_rd;
            tlb_addr_o = last_rd ? 4'd0 : cnt;
            if (probe_hit) begin
               cp0_index_we_o = 1'b1;
               cp0_index_o    = {28'd0, cmp_idx};
               done_o         = 1'b1;
            end else if (probe_miss) begin
               cp0_index_we_o = 1'b1;
               cp0_index_o    = PROBE_MISS;
               done_o         = 1'b1;
            end else begin
               cp0_index_we_o = 1'b0;
               cp0_index_o    = 32'd0;
               done_o         = 1'b0;
            end
         end
         default: begin
            tlb_re_o = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Bench for tlb_op_ctrl: TLB array model, per-operation expected-cycle model,
// directed scenarios with literal values, then randomized traffic.
module tb_tlb_op_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        op_valid;
   logic [2:0]  op;
   logic [31:0] index_v, random_v, entryhi_v, entrylo0_v, entrylo1_v;
   logic        tlb_re, tlb_we;
   logic [3:0]  tlb_addr;
   logic [95:0] tlb_wdata;
   logic [95:0] tlb_rdata = 96'd0;
   logic        cp0_tlb_we;
   logic [31:0] cp0_entryhi, cp0_entrylo0, cp0_entrylo1;
   logic        cp0_index_we;
   logic [31:0] cp0_index;
   logic        busy, done;

   always #5 clk = ~clk;

   tlb_op_ctrl dut (
      .clk(clk), .rst(rst), .op_valid_i(op_valid), .op_i(op),
      .index_i(index_v), .random_i(random_v), .entryhi_i(entryhi_v),
      .entrylo0_i(entrylo0_v), .entrylo1_i(entrylo1_v),
      .tlb_re_o(tlb_re), .tlb_we_o(tlb_we), .tlb_addr_o(tlb_addr),
      .tlb_wdata_o(tlb_wdata), .tlb_rdata_i(tlb_rdata),
      .cp0_tlb_we_o(cp0_tlb_we), .cp0_entryhi_o(cp0_entryhi),
      .cp0_entrylo0_o(cp0_entrylo0), .cp0_entrylo1_o(cp0_entrylo1),
      .cp0_index_we_o(cp0_index_we), .cp0_index_o(cp0_index),
      .busy_o(busy), .done_o(done)
   );

   typedef struct packed {
      logic        re;
      logic        we;
      logic [3:0]  addr;
      logic [95:0] wdata;
      logic        cp0_we;
      logic [31:0] ehi;
      logic [31:0] elo0;
      logic [31:0] elo1;
      logic        idx_we;
      logic [31:0] idx;
      logic        done;
   } exp_t;

   exp_t        q[$];
   logic [95:0] env_mem [16];
   logic [95:0] mdl_mem [16];
   logic        pl_we = 1'b0;
   logic [3:0]  pl_addr = 4'd0;
   logic [95:0] pl_data = 96'd0;
   int          n_checks = 0;
   int          n_fail = 0;
   bit          cmp_en = 1'b0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic exp_t blank();
      exp_t e;
      e = '0;
      return e;
   endfunction

   function automatic bit hit(input logic [95:0] r, input logic [31:0] h);
      return (r[95:77] == h[31:13]) && ((r[64] & r[32]) || (r[71:64] == h[7:0]));
   endfunction

   function automatic bit legal(input logic [2:0] c);
      return (c == 3'd1) || (c == 3'd2) || (c == 3'd3) || (c == 3'd4);
   endfunction

   // TLB array: writes from the DUT and from preloads, one-cycle read latency, junk otherwise.
   always @(posedge clk) begin
      if (tlb_we) env_mem[tlb_addr] <= tlb_wdata;
      if (pl_we)  env_mem[pl_addr]  <= pl_data;
      if (tlb_re) tlb_rdata <= env_mem[tlb_addr];
      else        tlb_rdata <= {$urandom, $urandom, $urandom};
   end

   // Expected per-cycle output list for one accepted operation.
   task automatic build(input logic [2:0] c, input logic [31:0] ix, input logic [31:0] rn,
                        input logic [31:0] h, input logic [31:0] l0, input logic [31:0] l1);
      exp_t e;
      int   k;
      int   n;
      if (c == 3'd1) begin
         e = blank(); e.re = 1'b1; e.addr = ix[3:0]; q.push_back(e);
         e = blank(); e.cp0_we = 1'b1; e.done = 1'b1;
         e.ehi = mdl_mem[ix[3:0]][95:64]; e.elo0 = mdl_mem[ix[3:0]][63:32];
         e.elo1 = mdl_mem[ix[3:0]][31:0];
         q.push_back(e);
      end else if (c == 3'd4) begin
         k = -1;
         for (int i = 15; i >= 0; i--) if (hit(mdl_mem[i], h)) k = i;
         n = (k >= 0) ? k + 2 : 17;
         for (int j = 1; j <= n; j++) begin
            e = blank();
            if (j <= 16) begin e.re = 1'b1; e.addr = 4'(j - 1); end
            if (j == n) begin
               e.idx_we = 1'b1; e.done = 1'b1;
               e.idx = (k >= 0) ? 32'(k) : 32'h8000_0000;
            end
            q.push_back(e);
         end
      end else begin
         e = blank(); e.we = 1'b1; e.done = 1'b1;
         e.addr = (c == 3'd3) ? rn[3:0] : ix[3:0];
         e.wdata = {h & ~32'h0000_1F00, l0, l1};
         q.push_back(e);
      end
   endtask

   // Reference model: retires the cycle that just ended, then considers a new request.
   initial begin
      forever begin
         @(posedge clk);
         if (q.size() > 0 && q[0].we) mdl_mem[q[0].addr] = q[0].wdata;
         if (pl_we) mdl_mem[pl_addr] = pl_data;
         if (rst) q.delete();
         else if (q.size() > 0) void'(q.pop_front());
         else if (op_valid && legal(op)) build(op, index_v, random_v, entryhi_v, entrylo0_v, entrylo1_v);
      end
   end

   // Every-cycle comparison of all outputs against the model.
   initial begin
      exp_t e, a;
      logic eb;
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            e  = (q.size() > 0) ? q[0] : blank();
            eb = (q.size() > 0);
            a.re = tlb_re; a.we = tlb_we; a.addr = tlb_addr; a.wdata = tlb_wdata;
            a.cp0_we = cp0_tlb_we; a.ehi = cp0_entryhi; a.elo0 = cp0_entrylo0;
            a.elo1 = cp0_entrylo1; a.idx_we = cp0_index_we; a.idx = cp0_index; a.done = done;
            check("cycle_outputs", {21'd0, a, busy}, {21'd0, e, eb});
         end
      end
   end

   task automatic scramble();
      index_v = $urandom; random_v = $urandom; entryhi_v = $urandom;
      entrylo0_v = $urandom; entrylo1_v = $urandom;
   endtask

   task automatic preload(input logic [3:0] a, input logic [95:0] d);
      @(negedge clk); pl_we = 1'b1; pl_addr = a; pl_data = d;
      @(negedge clk); pl_we = 1'b0;
   endtask

   task automatic issue(input logic [2:0] c, input logic [31:0] ix, input logic [31:0] rn,
                        input logic [31:0] h);
      @(negedge clk);
      op_valid = 1'b1; op = c; index_v = ix; random_v = rn; entryhi_v = h;
      entrylo0_v = 32'h0000_0000; entrylo1_v = 32'h0000_0000;
   endtask

   function automatic logic [31:0] make_hi();
      logic [18:0] vpn;
      logic [7:0]  asid;
      logic [4:0]  mid;
      case ($urandom_range(0, 3))
         0: vpn = 19'h00200;
         1: vpn = 19'h7FFFF;
         2: vpn = 19'h12345;
         default: vpn = 19'h00201;
      endcase
      case ($urandom_range(0, 3))
         0: asid = 8'h07;
         1: asid = 8'h05;
         2: asid = 8'hAA;
         default: asid = 8'h00;
      endcase
      mid = 5'($urandom_range(0, 31));
      return {vpn, mid, asid};
   endfunction

   initial begin
      int dn, rc, wc, iw;
      logic [3:0] wa;
      rst = 1'b1; op_valid = 1'b0; op = 3'd0;
      index_v = 32'd0; random_v = 32'd0; entryhi_v = 32'd0; entrylo0_v = 32'd0; entrylo1_v = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_strobes", {tlb_re, tlb_we, cp0_tlb_we, cp0_index_we}, 4'd0);
      check("rst_addr_wdata", {tlb_addr, tlb_wdata}, 100'd0);
      cmp_en = 1'b1;
      rst = 1'b0;
      for (int i = 0; i < 16; i++) preload(4'(i), {make_hi(), $urandom, $urandom});

      // TLBWI: entryhi bits 12:8 must be cleared in the written entry.
      issue(3'b010, 32'd5, 32'd0, 32'hABCD_F1FF);
      @(negedge clk); op_valid = 1'b0; scramble();
      check("wi_we", tlb_we, 1'b1);
      check("wi_addr", tlb_addr, 4'd5);
      check("wi_wdata_hi", tlb_wdata[95:64], 32'hABCD_E0FF);
      check("wi_done", done, 1'b1);
      @(negedge clk);
      check("wi_idle", busy, 1'b0);

      // TLBR of a preloaded entry.
      preload(4'd3, {32'h1000_2005, 32'h0000_0011, 32'h0000_0022});
      issue(3'b001, 32'd3, 32'd0, 32'd0);
      @(negedge clk); op_valid = 1'b0; scramble();
      check("r_re", {tlb_re, tlb_addr}, {1'b1, 4'd3});
      @(negedge clk);
      check("r_cp0_we", {cp0_tlb_we, done}, 2'b11);
      check("r_entries", {cp0_entryhi, cp0_entrylo0, cp0_entrylo1},
            {32'h1000_2005, 32'h0000_0011, 32'h0000_0022});
      @(negedge clk);

      // TLBP with matches at 6 and 9: lowest index wins.
      for (int i = 0; i < 16; i++) preload(4'(i), {32'hFFFF_E0AA, 64'd0});
      preload(4'd6, {32'h0040_0007, 64'd0});
      preload(4'd9, {32'h0040_0007, 64'd0});
      issue(3'b100, 32'd0, 32'd0, 32'h0040_0007);
      dn = 0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk); op_valid = 1'b0; scramble();
         if (c != 8) dn += int'(done);
         if (c == 8) begin
            check("p_hit_done", {done, cp0_index_we}, 2'b11);
            check("p_hit_index", cp0_index, 32'h0000_0006);
         end
      end
      check("p_hit_other_done", dn, 0);

      // TLBP with no match: full sweep, miss flag, exactly 16 reads.
      for (int i = 0; i < 16; i++) preload(4'(i), {32'h0040_0005, 64'd0});
      issue(3'b100, 32'd0, 32'd0, 32'h0040_0007);
      rc = 0; dn = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk); op_valid = 1'b0; scramble();
         rc += int'(tlb_re); dn += int'(done);
         if (c == 17) begin
            check("p_miss_done", {done, cp0_index_we, tlb_re}, 3'b110);
            check("p_miss_index", cp0_index, 32'h8000_0000);
         end
      end
      check("p_miss_reads", rc, 16);
      check("p_miss_done_count", dn, 1);

      // TLBWR with a TLBWI request arriving while busy.
      issue(3'b011, 32'd0, 32'd12, 32'h0000_0000);
      wc = 0; wa = 4'd0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (c == 1) begin op_valid = 1'b1; op = 3'b010; index_v = 32'd3; end
         else op_valid = 1'b0;
         if (tlb_we) begin wc++; wa = tlb_addr; end
      end
      check("wr_write_count", wc, 1);
      check("wr_write_addr", wa, 4'd12);

      // Reset in the middle of a probe aborts without an Index writeback.
      issue(3'b100, 32'd0, 32'd0, 32'h0040_0007);
      iw = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk); op_valid = 1'b0;
         if (c == 5) rst = 1'b1;
         if (c == 6) begin rst = 1'b0; check("p_rst_busy", busy, 1'b0); end
         iw += int'(cp0_index_we);
      end
      check("p_rst_no_index_we", iw, 0);

      // Randomized traffic against the model.
      for (int i = 0; i < 16; i++) preload(4'(i), {make_hi(), $urandom, $urandom});
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         rst = ($urandom_range(0, 499) == 0);
         op_valid = ($urandom_range(0, 2) != 0);
         op = 3'($urandom_range(0, 7));
         index_v = $urandom; random_v = $urandom; entryhi_v = make_hi();
         entrylo0_v = $urandom; entrylo1_v = $urandom;
      end
      @(negedge clk); rst = 1'b0; op_valid = 1'b0;
      repeat (25) @(negedge clk);
      check("final_idle", busy, 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
